// File: rtl/btn_pkg.sv
// Shared types and default timing for the push-button input chain (debouncer and event stage).
package btn_pkg;

  typedef enum logic [1:0] {IDLE, PRESS, LONG} btn_state_t;

  localparam int unsigned CNT_W = 32;

  // Default tick counts in clk cycles; the debouncer uses DEB_TICKS_DEF.
  localparam logic [CNT_W-1:0] DEB_TICKS_DEF    = 32'd5000;
  localparam logic [CNT_W-1:0] LONG_TICKS_DEF   = 32'd1000;
  localparam logic [CNT_W-1:0] REPEAT_TICKS_DEF = 32'd200;

endpackage

// File: rtl/btn_evt_if.sv
// Button event bundle: debounced level in, one-clock event strobes and held level out.
interface btn_evt_if;

  // release/repeat are SystemVerilog keywords, hence the _evt suffix.
  logic in;
  logic press;
  logic release_evt;
  logic long_press;
  logic repeat_evt;
  logic held;

  modport master (
    output in,
    input  press,
    input  release_evt,
    input  long_press,
    input  repeat_evt,
    input  held
  );

  modport slave (
    input  in,
    output press,
    output release_evt,
    output long_press,
    output repeat_evt,
    output held
  );

endinterface

// File: rtl/btn_evt_edge_det.sv
// Edge detector: registers a synchronous level and flags its rising and falling edges.
module btn_evt_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic lvl,
  output logic rise,
  output logic fall
);

  logic in_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      in_q <= 1'b0;
    end else begin
      in_q <= lvl;
    end
  end

  assign rise = lvl & ~in_q;
  assign fall = ~lvl & in_q;

endmodule

// File: rtl/btn_evt.sv
// Button event generator: press, release, long-press and held status from a debounced level.
// Auto-repeat strobes are built only when BTN_EVT_REPEAT_EN is defined.
module btn_evt
  import btn_pkg::*;
#(
  parameter logic [CNT_W-1:0] LONG_TICKS   = LONG_TICKS_DEF,
  parameter logic [CNT_W-1:0] REPEAT_TICKS = REPEAT_TICKS_DEF,
  parameter logic             ACTIVE_LOW   = 1'b0
) (
  input  logic      clk,
  input  logic      rst,
  btn_evt_if.slave  bus
);

  logic lvl, rise, fall;

  assign lvl = bus.in ^ ACTIVE_LOW;

  btn_evt_edge_det u_edge_det (
    .clk  (clk),
    .rst  (rst),
    .lvl  (lvl),
    .rise (rise),
    .fall (fall)
  );

  btn_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;
  logic             rel_q, rel_d;
  logic             long_q, long_d;
  logic             held_q, held_d;
`ifdef BTN_EVT_REPEAT_EN
  logic             rpt_q, rpt_d;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      long_q  <= 1'b0;
      held_q  <= 1'b0;
`ifdef BTN_EVT_REPEAT_EN
      rpt_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      long_q  <= long_d;
      held_q  <= held_d;
`ifdef BTN_EVT_REPEAT_EN
      rpt_q   <= rpt_d;
`endif
    end
  end

  // A fall always wins over a threshold hit in the same cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    long_d  = 1'b0;
    held_d  = held_q;
`ifdef BTN_EVT_REPEAT_EN
    rpt_d   = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (rise) begin
          press_d = 1'b1;
          held_d  = 1'b1;
          cnt_d   = '0;
          state_d = PRESS;
        end
      end
      PRESS: begin
        if (fall) begin
          rel_d   = 1'b1;
          held_d  = 1'b0;
          state_d = IDLE;
        end else if (cnt_q == LONG_TICKS - 32'd1) begin
          long_d  = 1'b1;
          cnt_d   = '0;
          state_d = LONG;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      LONG: begin
        if (fall) begin
          rel_d   = 1'b1;
          held_d  = 1'b0;
          state_d = IDLE;
        end
`ifdef BTN_EVT_REPEAT_EN
        else if (cnt_q == REPEAT_TICKS - 32'd1) begin
          rpt_d = 1'b1;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.press       = press_q;
  assign bus.release_evt = rel_q;
  assign bus.long_press  = long_q;
  assign bus.held        = held_q;

`ifdef BTN_EVT_REPEAT_EN
  assign bus.repeat_evt = rpt_q;
`else
  logic unused_repeat_ticks;
  assign unused_repeat_ticks = ^REPEAT_TICKS;
  assign bus.repeat_evt      = 1'b0;
`endif

endmodule
